// File: rtl/arbitro_mensagem_lcd_pkg.sv
// Shared definitions for the LCD message blocks: state encodings,
// the blank message, counter width and a mod-3 index helper.
package arbitro_mensagem_lcd_pkg;

    typedef enum logic [1:0] {
        INICIALIZANDO = 2'b00,
        LIVRE         = 2'b01,
        EXIBINDO      = 2'b10
    } estado_t;

    localparam int CNT_W = 16;

    localparam int MSG_BITS_PADRAO = 72;

    // Nine ASCII spaces: what the display shows before any grant.
    localparam logic [MSG_BITS_PADRAO-1:0] MSG_BRANCO = {9{8'h20}};

    // Next requester index modulo 3; an out-of-range index restarts at 0.
    function automatic logic [1:0] inc3(input logic [1:0] i);
        logic [1:0] r;
        unique case (i)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arbitro_mensagem_lcd_seletor_round_robin.sv
// Combinational round-robin pick among three requesters.
// Ports: req (requests), ptr (first index searched), vencedor (winner), valido (any request).
module seletor_round_robin
    import arbitro_mensagem_lcd_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] vencedor,
    output logic       valido
);

    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    // Search order ptr, ptr+1, ptr+2 (mod 3); ptr=3 is treated as 0.
    assign c0 = (ptr == 2'd3) ? 2'd0 : ptr;
    assign c1 = inc3(c0);
    assign c2 = inc3(c1);

    always_comb begin
        valido   = |req;
        vencedor = 2'd0;
        if (req[c0]) begin
            vencedor = c0;
        end else if (req[c1]) begin
            vencedor = c1;
        end else if (req[c2]) begin
            vencedor = c2;
        end
    end

endmodule

// File: rtl/arbitro_mensagem_lcd.sv
// Arbitrates three message sources onto one LCD: round-robin grant, then
// holds the granted message for HOLD_CYCLES before accepting another.
// Ports: Clock, Reset (async active-low), Inicializado (LCD ready),
// Req/Mensagem0..2 (requesters), Entrada (message to LCD), Ack (one-hot grant
// pulse), Dono (owner index), Ocupado (busy), Estado (debug state).
module arbitro_mensagem_lcd
    import arbitro_mensagem_lcd_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000,
    parameter int MSG_BITS    = 72
)
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Inicializado,
    input  logic [2:0]          Req,
    input  logic [MSG_BITS-1:0] Mensagem0,
    input  logic [MSG_BITS-1:0] Mensagem1,
    input  logic [MSG_BITS-1:0] Mensagem2,
    output logic [MSG_BITS-1:0] Entrada,
    output logic [2:0]          Ack,
    output logic [1:0]          Dono,
    output logic                Ocupado,
    output logic [1:0]          Estado
);

    localparam logic [MSG_BITS-1:0] BRANCO = MSG_BITS'(MSG_BRANCO);
    localparam logic [CNT_W-1:0]    CARGA  = CNT_W'(HOLD_CYCLES - 1);

    estado_t             estado_q;
    estado_t             estado_d;
    logic [MSG_BITS-1:0] entrada_q;
    logic [MSG_BITS-1:0] entrada_d;
    logic [2:0]          ack_q;
    logic [2:0]          ack_d;
    logic [1:0]          dono_q;
    logic [1:0]          dono_d;
    logic [1:0]          ptr_q;
    logic [1:0]          ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic [1:0]          vencedor;
    logic                valido;
    logic [MSG_BITS-1:0] msg_sel;

    seletor_round_robin u_sel (
        .req      (Req),
        .ptr      (ptr_q),
        .vencedor (vencedor),
        .valido   (valido)
    );

    always_comb begin
        unique case (vencedor)
            2'd1:    msg_sel = Mensagem1;
            2'd2:    msg_sel = Mensagem2;
            default: msg_sel = Mensagem0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q  <= INICIALIZANDO;
            entrada_q <= BRANCO;
            ack_q     <= 3'b000;
            dono_q    <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
        end else begin
            estado_q  <= estado_d;
            entrada_q <= entrada_d;
            ack_q     <= ack_d;
            dono_q    <= dono_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        entrada_d = entrada_q;
        ack_d     = 3'b000;
        dono_d    = dono_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        unique case (estado_q)
            INICIALIZANDO: begin
                cnt_d = '0;
                if (Inicializado) begin
                    estado_d = LIVRE;
                end
            end
            LIVRE: begin
                // Losing the LCD beats any pending grant.
                if (!Inicializado) begin
                    estado_d = INICIALIZANDO;
                    cnt_d    = '0;
                end else if (valido) begin
                    estado_d  = EXIBINDO;
                    entrada_d = msg_sel;
                    ack_d     = 3'b001 << vencedor;
                    dono_d    = vencedor;
                    cnt_d     = CARGA;
                end
            end
            EXIBINDO: begin
                if (!Inicializado) begin
                    estado_d = INICIALIZANDO;
                    cnt_d    = '0;
                end else if (cnt_q == '0) begin
                    estado_d = LIVRE;
                    ptr_d    = inc3(dono_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                estado_d = INICIALIZANDO;
                cnt_d    = '0;
            end
        endcase
    end

    assign Entrada = entrada_q;
    assign Ack     = ack_q;
    assign Dono    = dono_q;
    assign Estado  = estado_q;
    assign Ocupado = (estado_q == EXIBINDO);

endmodule

// File: tb/tb_arbitro_mensagem_lcd.sv
// Self-checking bench for arbitro_mensagem_lcd: table of per-cycle vectors
// on a HOLD_CYCLES=4 instance plus hand sequences on a HOLD_CYCLES=1 instance.
module tb_arbitro_mensagem_lcd;

    typedef struct packed {
        logic [2:0]  ack;
        logic [1:0]  dono;
        logic [1:0]  estado;
        logic        ocup;
        logic [71:0] ent;
    } obs_t;

    typedef struct {
        logic       inic;
        logic [2:0] req;
        logic [2:0] ack;
        logic [1:0] dono;
        logic [1:0] estado;
        int         msg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        inic;
    logic [2:0]  req;
    logic [71:0] m0;
    logic [71:0] m1;
    logic [71:0] m2;

    logic [71:0] ent4;
    logic [2:0]  ack4;
    logic [1:0]  dono4;
    logic        ocup4;
    logic [1:0]  est4;

    logic [71:0] ent1;
    logic [2:0]  ack1;
    logic [1:0]  dono1;
    logic        ocup1;
    logic [1:0]  est1;

    int errors;
    int checks;

    obs_t sb[$];
    vec_t tab[30];

    arbitro_mensagem_lcd #(.HOLD_CYCLES(4), .MSG_BITS(72)) dut4 (
        .Clock(clk), .Reset(rst_n), .Inicializado(inic), .Req(req),
        .Mensagem0(m0), .Mensagem1(m1), .Mensagem2(m2),
        .Entrada(ent4), .Ack(ack4), .Dono(dono4),
        .Ocupado(ocup4), .Estado(est4)
    );

    arbitro_mensagem_lcd #(.HOLD_CYCLES(1), .MSG_BITS(72)) dut1 (
        .Clock(clk), .Reset(rst_n), .Inicializado(inic), .Req(req),
        .Mensagem0(m0), .Mensagem1(m1), .Mensagem2(m2),
        .Entrada(ent1), .Ack(ack1), .Dono(dono1),
        .Ocupado(ocup1), .Estado(est1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [71:0] msg_of(input int i);
        logic [71:0] r;
        case (i)
            0:       r = m0;
            1:       r = m1;
            2:       r = m2;
            default: r = {9{8'h20}};
        endcase
        return r;
    endfunction

    function automatic obs_t mk(input logic [2:0] a, input logic [1:0] d,
                                input logic [1:0] e, input int msg);
        obs_t o;
        o.ack    = a;
        o.dono   = d;
        o.estado = e;
        o.ocup   = (e == 2'b10);
        o.ent    = msg_of(msg);
        return o;
    endfunction

    function automatic obs_t obs4();
        obs_t o;
        o.ack = ack4; o.dono = dono4; o.estado = est4;
        o.ocup = ocup4; o.ent = ent4;
        return o;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.ack = ack1; o.dono = dono1; o.estado = est1;
        o.ocup = ocup1; o.ent = ent1;
        return o;
    endfunction

    task automatic cmp(input string nm, input obs_t e, input obs_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got ack=%b dono=%0d est=%b ocup=%b ent=%h, want ack=%b dono=%0d est=%b ocup=%b ent=%h",
                     nm, a.ack, a.dono, a.estado, a.ocup, a.ent,
                     e.ack, e.dono, e.estado, e.ocup, e.ent);
        end
    endtask

    // Drive one cycle on the inactive edge, queue its expectation, check after the edge.
    task automatic step(input string nm, input bit use1, input logic i,
                        input logic [2:0] r, input obs_t e);
        obs_t x;
        @(negedge clk);
        inic = i;
        req  = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = sb.pop_front();
            cmp(nm, x, use1 ? obs1() : obs4());
        end
    endtask

    initial begin
        obs_t rst_val;
        errors = 0;
        checks = 0;
        m0 = "PLACAR 00";
        m1 = "MSG UM   ";
        m2 = "MSG DOIS ";
        rst_n = 1'b0;
        inic  = 1'b0;
        req   = 3'b111;

        tab = '{
            '{1'b0, 3'b111, 3'b000, 2'd0, 2'b00, 3},
            '{1'b0, 3'b111, 3'b000, 2'd0, 2'b00, 3},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b01, 3},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b01, 3},
            '{1'b1, 3'b001, 3'b001, 2'd0, 2'b10, 0},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b10, 0},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b10, 0},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b10, 0},
            '{1'b1, 3'b000, 3'b000, 2'd0, 2'b01, 0},
            '{1'b1, 3'b111, 3'b010, 2'd1, 2'b10, 1},
            '{1'b1, 3'b111, 3'b000, 2'd1, 2'b10, 1},
            '{1'b1, 3'b111, 3'b000, 2'd1, 2'b10, 1},
            '{1'b1, 3'b111, 3'b000, 2'd1, 2'b10, 1},
            '{1'b1, 3'b111, 3'b000, 2'd1, 2'b01, 1},
            '{1'b1, 3'b111, 3'b100, 2'd2, 2'b10, 2},
            '{1'b1, 3'b111, 3'b000, 2'd2, 2'b10, 2},
            '{1'b1, 3'b111, 3'b000, 2'd2, 2'b10, 2},
            '{1'b1, 3'b111, 3'b000, 2'd2, 2'b10, 2},
            '{1'b1, 3'b111, 3'b000, 2'd2, 2'b01, 2},
            '{1'b1, 3'b111, 3'b001, 2'd0, 2'b10, 0},
            '{1'b1, 3'b111, 3'b000, 2'd0, 2'b10, 0},
            '{1'b0, 3'b111, 3'b000, 2'd0, 2'b00, 0},
            '{1'b0, 3'b111, 3'b000, 2'd0, 2'b00, 0},
            '{1'b1, 3'b111, 3'b000, 2'd0, 2'b01, 0},
            '{1'b1, 3'b010, 3'b010, 2'd1, 2'b10, 1},
            '{1'b0, 3'b010, 3'b000, 2'd1, 2'b00, 1},
            '{1'b1, 3'b000, 3'b000, 2'd1, 2'b01, 1},
            '{1'b0, 3'b111, 3'b000, 2'd1, 2'b00, 1},
            '{1'b1, 3'b000, 3'b000, 2'd1, 2'b01, 1},
            '{1'b1, 3'b100, 3'b100, 2'd2, 2'b10, 2}
        };

        rst_val = mk(3'b000, 2'd0, 2'b00, 3);

        // Held in reset with everything requesting: nothing may move.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("reset4_%0d", c), rst_val, obs4());
            cmp($sformatf("reset1_%0d", c), rst_val, obs1());
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 30; k++) begin
            step($sformatf("vec%0d", k), 1'b0, tab[k].inic, tab[k].req,
                 mk(tab[k].ack, tab[k].dono, tab[k].estado, tab[k].msg));
        end

        // Asynchronous reset in mid-cycle while displaying.
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst4", rst_val, obs4());
        cmp("async_rst1", rst_val, obs1());

        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle hold: one EXIBINDO cycle, then rotation back to 0.
        step("h1_init",  1'b1, 1'b1, 3'b000, mk(3'b000, 2'd0, 2'b01, 3));
        step("h1_grant2", 1'b1, 1'b1, 3'b100, mk(3'b100, 2'd2, 2'b10, 2));
        step("h1_free",  1'b1, 1'b1, 3'b100, mk(3'b000, 2'd2, 2'b01, 2));
        step("h1_ptr0",  1'b1, 1'b1, 3'b111, mk(3'b001, 2'd0, 2'b10, 0));
        step("h1_free2", 1'b1, 1'b1, 3'b000, mk(3'b000, 2'd0, 2'b01, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_mensagem_lcd.md
ARBITRO_MENSAGEM_LCD -- requirements
Module: arbitro_mensagem_lcd

Interface
REQ-001 Parameter: HOLD_CYCLES, 50000, minimum cycles a granted message stays on Entrada (legal range 1..65535).
REQ-002 Parameter: MSG_BITS, 72, message width (9 ASCII chars, char 0 in [71:64]).
REQ-003 Port: Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-low reset.
REQ-005 Port: Inicializado  input  1  high when the LCD controller has finished its init sequence.
REQ-006 Port: Req  input  3  per-requester request, level, held until Ack.
REQ-007 Port: Mensagem0 / Mensagem1 / Mensagem2  input  MSG_BITS each  message offered by each requester, valid while its Req is high.
REQ-008 Port: Entrada  output  MSG_BITS  registered message driven to the LCD controller.
REQ-009 Port: Ack  output  3  one-hot, one-cycle grant pulse.
REQ-010 Port: Dono  output  2  index of current/last owner (0..2).
REQ-011 Port: Ocupado  output  1  high while state is EXIBINDO.
REQ-012 Port: Estado  output  2  current state encoding, for debug.

Function
REQ-013 States: INICIALIZANDO (2'b00), LIVRE (2'b01), EXIBINDO (2'b10); 2'b11 unused, SHALL recover to INICIALIZANDO.
REQ-014 INICIALIZANDO -> LIVRE on the first edge where Inicializado=1; Req ignored, Ack=0 while INICIALIZANDO.
REQ-015 LIVRE, no Req bit set: stay LIVRE, outputs hold.
REQ-016 LIVRE, any Req set: round-robin select, search order starting at pointer Ptr, then Ptr+1, Ptr+2 (mod 3, 2 wraps to 0).
REQ-017 On grant edge: Entrada <= selected Mensagem, Ack[winner] <= 1 for exactly one cycle, Dono <= winner, counter <= HOLD_CYCLES-1, state <= EXIBINDO.
REQ-018 Latency: Req sampled high at edge N -> Ack and new Entrada visible after edge N (one cycle), when state was LIVRE at edge N.
REQ-019 EXIBINDO: counter decrements each cycle; all Req ignored; Entrada stable.
REQ-020 EXIBINDO with counter=0: state <= LIVRE, Ptr <= (Dono+1) mod 3; HOLD_CYCLES=1 gives exactly one EXIBINDO cycle.
REQ-021 Entrada retains last granted message in LIVRE (display persists until next grant).
REQ-022 Inicializado=0 in LIVRE or EXIBINDO: next state INICIALIZANDO, counter cleared, Ack=0; Entrada, Dono, Ptr retained; this takes priority over counter expiry and grant in the same cycle.
REQ-023 Requester still holding Req after its Ack re-competes on next LIVRE; rotation guarantees any waiting requester is granted within 3 grants.
REQ-024 Counter width 16 bits, unsigned, no wrap below 0.

Reset
REQ-025 Reset low asynchronously forces: state INICIALIZANDO, Entrada = {9{8'h20}} (nine spaces), Ack=0, Dono=0, Ptr=0, counter=0, Ocupado=0.
REQ-026 Reset release mid-transfer is not resumed; block restarts from INICIALIZANDO.

Structure
REQ-027 State encodings, blank-message constant and counter width SHALL live in a shared package/include used by the LCD blocks.
REQ-028 Round-robin selection SHALL be one sub-module, seletor_round_robin (inputs Req, Ptr; outputs winner index, valid), combinational.
REQ-029 Single always block per register group; no latches; Ack derived only from registered state.

Verification
REQ-030 Reset low, Inicializado=0, Req=3'b111 -> Entrada=72'h202020202020202020, Ack=0, Estado=00 indefinitely.
REQ-031 Inicializado rises at edge 10, Req0 with "PLACAR 00" at edge 12 -> Ack=3'b001 one cycle after edge 12, Entrada="PLACAR 00", Ocupado high for HOLD_CYCLES cycles.
REQ-032 HOLD_CYCLES=4, Req=3'b111 held -> grant order 0,1,2,0 with Ack pulses 5 cycles apart.
REQ-033 HOLD_CYCLES=4, Req1 grant, Inicializado dropped at 2nd EXIBINDO cycle -> Estado=00 next cycle, Entrada unchanged, no Ack until re-init.
REQ-034 HOLD_CYCLES=1, Req2 only -> Ack2 then LIVRE after one EXIBINDO cycle; Ptr=0.
REQ-035 Reset asserted mid-EXIBINDO -> all outputs at reset values immediately, without waiting for Clock.
